// File: rtl/cdb_arbiter_pkg.sv
// Shared definitions for the common-data-bus arbiter: widths, boolean
// constants, source encodings and the round-robin pick helper.
package cdb_arbiter_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ROB_WIDTH  = 4;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  localparam logic CDB_SRC_ALU = 1'b0;
  localparam logic CDB_SRC_LSU = 1'b1;

  typedef enum logic {
    SRC_ALU = CDB_SRC_ALU,
    SRC_LSU = CDB_SRC_LSU
  } cdb_src_e;

  // Round-robin choice: under contention the source that did not win last
  // time goes next; otherwise whichever source has something pending.
  function automatic cdb_src_e rr_pick(input logic alu_ne, input logic lsu_ne,
                                       input cdb_src_e last_grant);
    cdb_src_e pick;
    if (alu_ne && lsu_ne) begin
      pick = (last_grant == SRC_LSU) ? SRC_ALU : SRC_LSU;
    end else if (lsu_ne) begin
      pick = SRC_LSU;
    end else begin
      pick = SRC_ALU;
    end
    return pick;
  endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Producer handshakes and broadcast bus of the common-data-bus arbiter.
// The arbiter uses the slave view; producers/consumers use the master view.
interface cdb_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ROB_W  = 4
);

  logic              alu_valid_in;
  logic [ROB_W-1:0]  alu_reorder_in;
  logic [DATA_W-1:0] alu_value_in;
  logic              alu_ready_out;

  logic              lsu_valid_in;
  logic [ROB_W-1:0]  lsu_reorder_in;
  logic [DATA_W-1:0] lsu_value_in;
  logic              lsu_ready_out;

  logic              cdb_enable_out;
  logic [ROB_W-1:0]  cdb_reorder_out;
  logic [DATA_W-1:0] cdb_value_out;
  logic              cdb_src_out;

  modport slave (
    input  alu_valid_in, alu_reorder_in, alu_value_in,
    output alu_ready_out,
    input  lsu_valid_in, lsu_reorder_in, lsu_value_in,
    output lsu_ready_out,
    output cdb_enable_out, cdb_reorder_out, cdb_value_out, cdb_src_out
  );

  modport master (
    output alu_valid_in, alu_reorder_in, alu_value_in,
    input  alu_ready_out,
    output lsu_valid_in, lsu_reorder_in, lsu_value_in,
    input  lsu_ready_out,
    input  cdb_enable_out, cdb_reorder_out, cdb_value_out, cdb_src_out
  );

endinterface

// File: rtl/cdb_arbiter_src_fifo.sv
// Per-source result FIFO holding (reorder, value) pairs. Push and pop are
// already qualified by the caller; flush empties it, reset overrides all.
module cdb_src_fifo
  import cdb_arbiter_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int DATA_W = DATA_WIDTH,
  parameter int ROB_W  = ROB_WIDTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              push_in,
  input  logic              pop_in,
  input  logic              flush_in,
  input  logic [ROB_W-1:0]  push_tag_in,
  input  logic [DATA_W-1:0] push_value_in,
  output logic [ROB_W-1:0]  head_tag_out,
  output logic [DATA_W-1:0] head_value_out,
  output logic              empty_out,
  output logic              full_out,
  output logic [CNT_W-1:0]  count_out
);

  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [ROB_W-1:0]  r_tag_mem [DEPTH];
  logic [DATA_W-1:0] r_val_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge clk_in) begin
    if (push_in && !flush_in && !rst_in) begin
      r_tag_mem[r_wr_ptr] <= push_tag_in;
      r_val_mem[r_wr_ptr] <= push_value_in;
    end
  end

  // Pointer and occupancy bookkeeping; simultaneous push/pop keeps count.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush_in) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push_in) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (pop_in)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({push_in, pop_in})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  assign head_tag_out   = r_tag_mem[r_rd_ptr];
  assign head_value_out = r_val_mem[r_rd_ptr];
  assign empty_out      = (r_count == '0);
  assign full_out       = (r_count == CNT_FULL);
  assign count_out      = r_count;

endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: two source FIFOs (ALU, LSU) feeding one
// registered broadcast port, granted round-robin one result per cycle.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int DATA_W     = DATA_WIDTH,
  parameter int ROB_W      = ROB_WIDTH,
  localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          rdy_in,
  input  logic          flush_in,
  cdb_arbiter_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  logic              w_alu_push, w_lsu_push, w_alu_pop, w_lsu_pop, w_flush;
  logic [ROB_W-1:0]  w_alu_tag, w_lsu_tag, w_head_tag;
  logic [DATA_W-1:0] w_alu_val, w_lsu_val, w_head_val;
  logic              w_alu_empty, w_lsu_empty, w_alu_full, w_lsu_full;
  logic [CNT_W-1:0]  w_alu_count, w_lsu_count;
  logic              w_grant;
  cdb_src_e          w_grant_src;

  logic              r_cdb_enable;
  logic [ROB_W-1:0]  r_cdb_tag;
  logic [DATA_W-1:0] r_cdb_val;
  cdb_src_e          r_cdb_src;
  cdb_src_e          r_last_grant;

  // Ready depends on registered occupancy only, so a same-cycle pop
  // never re-opens a full FIFO.
  assign bus.alu_ready_out = (w_alu_count != CNT_FULL);
  assign bus.lsu_ready_out = (w_lsu_count != CNT_FULL);

  assign w_flush    = flush_in && rdy_in;
  assign w_alu_push = bus.alu_valid_in && !w_alu_full && rdy_in && !flush_in;
  assign w_lsu_push = bus.lsu_valid_in && !w_lsu_full && rdy_in && !flush_in;
  assign w_alu_pop  = w_grant && (w_grant_src == SRC_ALU) && rdy_in && !flush_in;
  assign w_lsu_pop  = w_grant && (w_grant_src == SRC_LSU) && rdy_in && !flush_in;

  cdb_src_fifo #(.DEPTH(FIFO_DEPTH), .DATA_W(DATA_W), .ROB_W(ROB_W)) u_alu_fifo (
    .clk_in(clk_in), .rst_in(rst_in),
    .push_in(w_alu_push), .pop_in(w_alu_pop), .flush_in(w_flush),
    .push_tag_in(bus.alu_reorder_in), .push_value_in(bus.alu_value_in),
    .head_tag_out(w_alu_tag), .head_value_out(w_alu_val),
    .empty_out(w_alu_empty), .full_out(w_alu_full), .count_out(w_alu_count)
  );

  cdb_src_fifo #(.DEPTH(FIFO_DEPTH), .DATA_W(DATA_W), .ROB_W(ROB_W)) u_lsu_fifo (
    .clk_in(clk_in), .rst_in(rst_in),
    .push_in(w_lsu_push), .pop_in(w_lsu_pop), .flush_in(w_flush),
    .push_tag_in(bus.lsu_reorder_in), .push_value_in(bus.lsu_value_in),
    .head_tag_out(w_lsu_tag), .head_value_out(w_lsu_val),
    .empty_out(w_lsu_empty), .full_out(w_lsu_full), .count_out(w_lsu_count)
  );

  // Choose the winning source and select its FIFO head.
  always_comb begin
    w_grant     = !w_alu_empty || !w_lsu_empty;
    w_grant_src = rr_pick(!w_alu_empty, !w_lsu_empty, r_last_grant);
    w_head_tag  = w_alu_tag;
    w_head_val  = w_alu_val;
    if (w_grant_src == SRC_LSU) begin
      w_head_tag = w_lsu_tag;
      w_head_val = w_lsu_val;
    end else begin
      w_head_tag = w_alu_tag;
      w_head_val = w_alu_val;
    end
  end

  // Broadcast register and round-robin history; everything freezes while
  // rdy_in is low, and tag/value/src hold whenever nothing is granted.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_cdb_enable <= FALSE;
      r_cdb_tag    <= '0;
      r_cdb_val    <= '0;
      r_cdb_src    <= SRC_ALU;
      r_last_grant <= SRC_LSU;
    end else if (rdy_in) begin
      if (flush_in) begin
        r_cdb_enable <= FALSE;
        r_last_grant <= SRC_LSU;
      end else if (w_grant) begin
        r_cdb_enable <= TRUE;
        r_cdb_tag    <= w_head_tag;
        r_cdb_val    <= w_head_val;
        r_cdb_src    <= w_grant_src;
        r_last_grant <= w_grant_src;
      end else begin
        r_cdb_enable <= FALSE;
      end
    end
  end

  assign bus.cdb_enable_out  = r_cdb_enable;
  assign bus.cdb_reorder_out = r_cdb_tag;
  assign bus.cdb_value_out   = r_cdb_val;
  assign bus.cdb_src_out     = r_cdb_src;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: a queue-level reference model predicts
// the bus state after every clock edge; a monitor compares independently.
module tb_cdb_arbiter;

  localparam int DEPTH = 2;
  localparam int DW    = 32;
  localparam int RW    = 4;

  logic clk = 1'b0;
  logic rst_in, rdy_in, flush_in;

  always #5 clk = ~clk;

  cdb_arbiter_if #(.DATA_W(DW), .ROB_W(RW)) bus();

  cdb_arbiter #(.FIFO_DEPTH(DEPTH), .DATA_W(DW), .ROB_W(RW)) dut (
    .clk_in(clk), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in), .bus(bus)
  );

  typedef struct packed {
    logic          en;
    logic [RW-1:0] tag;
    logic [DW-1:0] val;
    logic          src;
  } rec_t;

  rec_t             exp_q[$];
  logic [RW+DW-1:0] alu_q[$];
  logic [RW+DW-1:0] lsu_q[$];
  rec_t             last_out;
  logic             last_src;
  int               vectors = 0;
  int               miscompares = 0;

  // Apply one cycle of stimulus, predict the bus after the coming edge,
  // then check the producer readies once that edge has passed.
  task automatic step(input logic rst, input logic rdy, input logic flush,
                      input logic av, input logic [RW-1:0] at, input logic [DW-1:0] aval,
                      input logic lv, input logic [RW-1:0] lt, input logic [DW-1:0] lval);
    logic a_rdy, l_rdy;
    logic [RW+DW-1:0] e;
    rst_in = rst; rdy_in = rdy; flush_in = flush;
    bus.alu_valid_in = av; bus.alu_reorder_in = at; bus.alu_value_in = aval;
    bus.lsu_valid_in = lv; bus.lsu_reorder_in = lt; bus.lsu_value_in = lval;
    a_rdy = (alu_q.size() != DEPTH);
    l_rdy = (lsu_q.size() != DEPTH);
    if (rst) begin
      alu_q.delete(); lsu_q.delete();
      last_src = 1'b1;
      last_out = '0;
    end else if (rdy) begin
      if (flush) begin
        alu_q.delete(); lsu_q.delete();
        last_src = 1'b1;
        last_out.en = 1'b0;
      end else begin
        if (alu_q.size() > 0 && (lsu_q.size() == 0 || last_src == 1'b1)) begin
          e = alu_q.pop_front();
          last_out.en = 1'b1; last_out.tag = e[RW+DW-1:DW]; last_out.val = e[DW-1:0];
          last_out.src = 1'b0; last_src = 1'b0;
        end else if (lsu_q.size() > 0) begin
          e = lsu_q.pop_front();
          last_out.en = 1'b1; last_out.tag = e[RW+DW-1:DW]; last_out.val = e[DW-1:0];
          last_out.src = 1'b1; last_src = 1'b1;
        end else begin
          last_out.en = 1'b0;
        end
        if (av && a_rdy) alu_q.push_back({at, aval});
        if (lv && l_rdy) lsu_q.push_back({lt, lval});
      end
    end
    exp_q.push_back(last_out);
    @(negedge clk);
    vectors++;
    if (bus.alu_ready_out !== (alu_q.size() != DEPTH)) begin
      miscompares++;
      $display("FAIL alu_ready t=%0t got %b exp %b", $time, bus.alu_ready_out, alu_q.size() != DEPTH);
    end
    vectors++;
    if (bus.lsu_ready_out !== (lsu_q.size() != DEPTH)) begin
      miscompares++;
      $display("FAIL lsu_ready t=%0t got %b exp %b", $time, bus.lsu_ready_out, lsu_q.size() != DEPTH);
    end
  endtask

  task automatic rnd_step(input logic rst, input logic rdy, input logic flush,
                          input logic av, input logic lv);
    step(rst, rdy, flush, av, RW'($urandom), $urandom, lv, RW'($urandom), $urandom);
  endtask

  // Monitor: after every edge compare the bus with the oldest prediction.
  initial begin
    rec_t got, exp_r;
    forever begin
      @(posedge clk);
      #1;
      got.en = bus.cdb_enable_out; got.tag = bus.cdb_reorder_out;
      got.val = bus.cdb_value_out; got.src = bus.cdb_src_out;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL cdb_underflow t=%0t got en=%b tag=%0d no prediction", $time, got.en, got.tag);
      end else begin
        exp_r = exp_q.pop_front();
        if (got !== exp_r) begin
          miscompares++;
          $display("FAIL cdb t=%0t got en=%b tag=%0d val=%h src=%b exp en=%b tag=%0d val=%h src=%b",
                   $time, got.en, got.tag, got.val, got.src, exp_r.en, exp_r.tag, exp_r.val, exp_r.src);
        end
      end
    end
  end

  // Stimulus: directed scenarios first, then a randomized soak.
  initial begin
    last_out = '0;
    last_src = 1'b1;
    rnd_step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    rnd_step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    // Single ALU result, visible two cycles later.
    step(1'b0, 1'b1, 1'b0, 1'b1, 4'd3, 32'h11, 1'b0, 4'd0, 32'h0);
    for (int i = 0; i < 3; i++) rnd_step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    // Simultaneous push: ALU first, then LSU.
    step(1'b0, 1'b1, 1'b0, 1'b1, 4'd1, 32'h101, 1'b1, 4'd2, 32'h202);
    for (int i = 0; i < 3; i++) rnd_step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    // Backpressure: both push every cycle.
    for (int i = 0; i < 6; i++) rnd_step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) rnd_step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    // Flush with entries pending in both FIFOs.
    for (int i = 0; i < 3; i++) rnd_step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    rnd_step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) rnd_step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    // Stall: one pending entry held while rdy_in is low.
    rnd_step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) rnd_step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) rnd_step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    // Reset mid-burst, then contention must go to the ALU first.
    for (int i = 0; i < 3; i++) rnd_step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    rnd_step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    rnd_step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) rnd_step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    // Randomized soak.
    for (int i = 0; i < 2000; i++) begin
      rnd_step($urandom_range(0, 199) == 0, $urandom_range(0, 5) != 0,
               $urandom_range(0, 39) == 0,
               $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 6);
    end
    for (int i = 0; i < 4; i++) rnd_step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain got %0d pending predictions exp 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Common-data-bus arbiter between the execution units and the reservation station's bypass inputs. Two result producers (ALU, LSU) each push `(reorder, value)` results into a private FIFO. The block grants one result per cycle, round-robin, onto a single registered broadcast port that feeds the reservation station, load/store buffer and ROB. This replaces the dual alu/lsu bypass ports with one arbitrated bus and absorbs bursts so neither unit stalls on a shared slot.

## Interface
Parameters:
- `FIFO_DEPTH`, default 2: entries per source FIFO, power of two, minimum 2.
- `DATA_W`, default 32: result value width (`DATA_WIDTH`).
- `ROB_W`, default 4: reorder tag width (`ROB_WIDTH`).

Ports (one clock; reset is synchronous and active-high):
- `clk_in` in 1: clock.
- `rst_in` in 1: synchronous reset, active high.
- `rdy_in` in 1: global enable; when low, all state freezes.
- `flush_in` in 1: mispredict flush; drop all pending results.
- `alu_valid_in` in 1: ALU result valid.
- `alu_reorder_in` in `ROB_W`: ALU destination tag.
- `alu_value_in` in `DATA_W`: ALU result.
- `alu_ready_out` out 1: ALU FIFO can accept.
- `lsu_valid_in`, `lsu_reorder_in`, `lsu_value_in`, `lsu_ready_out`: same as the ALU set, for the LSU.
- `cdb_enable_out` out 1: broadcast valid, one cycle per result.
- `cdb_reorder_out` out `ROB_W`: broadcast tag.
- `cdb_value_out` out `DATA_W`: broadcast value.
- `cdb_src_out` out 1: 0 = ALU, 1 = LSU (debug/perf).

## Operation
- **Push:** a source entry is written at the edge when `valid && ready && rdy_in && !flush_in && !rst_in`. Values presented while ready is low are dropped; the producer must hold them.
- **Ready:** `x_ready_out = (count_x != FIFO_DEPTH)`, from registered count only. A same-cycle pop does not raise ready.
- **Grant:** evaluated each `rdy_in` cycle on the FIFO heads.
  - Neither source non-empty: no grant.
  - One non-empty: grant it.
  - Both non-empty: grant the source opposite `last_grant`.
- **On grant:** pop the head, register it onto the cdb outputs with `cdb_enable_out = 1`, and update `last_grant`.
- **No grant:** `cdb_enable_out = 0`; tag, value and src hold their previous values.
- **FIFO pointers:** ordered per source, `$clog2(FIFO_DEPTH)` bits, wrap naturally. The count is `$clog2(FIFO_DEPTH)+1` bits.
- **Simultaneous push and pop on one FIFO:** count unchanged, both take effect. A push into a full FIFO cannot happen because ready is low.
- **Flush** (`rdy_in` high):
  - both FIFOs emptied, `cdb_enable_out <= 0`, `last_grant <= LSU`;
  - pushes and grants in that cycle are discarded.
  - Flush is sampled only while `rdy_in` is high; the issuer holds it.
- **`rdy_in` low:** no push, no pop, no grant. Outputs hold, including `cdb_enable_out`. Downstream also ignores the bus while `rdy_in` is low.
- **Reset:** overrides everything.

## Timing
- Reset values:
  - `cdb_enable_out = 0`, `cdb_reorder_out = 0`, `cdb_value_out = 0`, `cdb_src_out = 0`;
  - both FIFOs empty, `alu_ready_out = lsu_ready_out = 1`, `last_grant = LSU` (ALU wins first contention).
- **Latency:** result accepted at edge E, visible at a FIFO head after E, broadcast registered at E+1. `cdb_enable_out` is high in the cycle after E+1, i.e. 2 cycles from valid to broadcast when uncontended.
- **Throughput:** 1 broadcast per cycle total. Under sustained contention each source gets exactly every other cycle.
- **Mid-operation reset or flush:** the next cycle shows `cdb_enable_out = 0` and both readies high.

## Structure
- Shared defines header (existing): `DATA_WIDTH`, `ROB_WIDTH`, `TRUE`/`FALSE`, plus new `CDB_SRC_ALU` = 1'b0 and `CDB_SRC_LSU` = 1'b1.
- Sub-module `cdb_src_fifo`, instantiated twice.
  - Parameterised by depth and widths.
  - Ports: push/pop/flush, head data, empty, full, count.
- The top level holds the round-robin grant logic and the output register.

## Test plan
- **Single ALU result:** ALU pushes (tag 3, value 0x11) at cycle 0 → `cdb_enable_out = 1`, tag 3, value 0x11, src 0 at cycle 2; enable low at cycle 3.
- **Simultaneous push:** both push at cycle 0 (ALU tag 1, LSU tag 2) → cycle 2 broadcasts ALU tag 1, cycle 3 broadcasts LSU tag 2; then `last_grant = LSU`.
- **Backpressure:** both push every cycle for 6 cycles, depth 2.
  - Broadcasts alternate ALU, LSU, ALU, …
  - Each ready deasserts once its FIFO is full.
  - No tag is lost or duplicated; per-source order is preserved.
- **Flush:** flush asserted with 2 entries pending per FIFO → next cycle enable 0, both readies 1. No flushed tag is ever broadcast.
- **Stall:** `rdy_in` low for 3 cycles with one pending entry → outputs frozen; broadcast occurs on the first cycle after `rdy_in` returns high.
- **Reset mid-burst:** `rst_in` pulsed mid-burst → all outputs reach reset values next cycle. The first post-reset contention grants the ALU.
